load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and RAM port bundle for load_store_unit.
// Handshake: start is taken only while busy=0; done pulses once per accepted request with err valid alongside it.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                    start;
  logic                    is_store;
  logic [2:0]              funct3;
  logic [ADDR_WIDTH+1:0]   addr;
  logic [31:0]             store_data;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [31:0]             load_data;
  logic [ADDR_WIDTH-1:0]   ram_address;
  logic [31:0]             ram_data_in;
  logic                    ram_write;
  logic                    ram_read;
  logic [31:0]             ram_data_out;
  logic [2:0]              fsm_state;

  modport master (
    output start, is_store, funct3, addr, store_data, ram_data_out,
    input  busy, done, err, load_data, ram_address, ram_data_in,
           ram_write, ram_read, fsm_state
  );

  modport slave (
    input  start, is_store, funct3, addr, store_data, ram_data_out,
    output busy, done, err, load_data, ram_address, ram_data_in,
           ram_write, ram_read, fsm_state
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I-style byte/half/word load-store unit for a single-port word RAM.
// Sub-word stores are done as read-modify-write; the FSM state is exported on bus.fsm_state.
module load_store_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("load_store_unit: DATA_WIDTH must be 32");
  end

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t                state, state_next;
  logic                  op_store;
  logic [2:0]            op_f3;
  logic [ADDR_WIDTH+1:0] op_addr;
  logic [15:0]           op_data;
  logic                  op_err;
  logic [31:0]           load_q;
  logic [31:0]           wdata_q;

  logic        accept, legal_f3, misaligned, req_err, req_sw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] formatted, merged;

  assign accept   = bus.start && (state == IDLE);
  assign legal_f3 = bus.is_store ? (bus.funct3 inside {3'b000, 3'b001, 3'b010})
                                 : (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                      ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
  assign req_err  = !legal_f3 || misaligned;
  // Full-word stores need no read, so they skip straight to WR.
  assign req_sw   = bus.is_store && (bus.funct3 == 3'b010);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)     state_next = RESP;
        else if (req_sw) state_next = WR;
        else             state_next = RD;
      end
      RD:      state_next = CAP;
      CAP:     state_next = op_store ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (op_addr[1:0])
      2'd0:    byte_sel = bus.ram_data_out[7:0];
      2'd1:    byte_sel = bus.ram_data_out[15:8];
      2'd2:    byte_sel = bus.ram_data_out[23:16];
      default: byte_sel = bus.ram_data_out[31:24];
    endcase
    half_sel = op_addr[1] ? bus.ram_data_out[31:16] : bus.ram_data_out[15:0];
    // funct3[2] marks the unsigned variants.
    case (op_f3[1:0])
      2'b00:   formatted = {{24{byte_sel[7] & ~op_f3[2]}}, byte_sel};
      2'b01:   formatted = {{16{half_sel[15] & ~op_f3[2]}}, half_sel};
      default: formatted = bus.ram_data_out;
    endcase
    merged = bus.ram_data_out;
    if (op_f3[1:0] == 2'b00) merged[{op_addr[1:0], 3'b000} +: 8]  = op_data[7:0];
    else                     merged[{op_addr[1], 4'b0000} +: 16] = op_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_store <= 1'b0;
      op_f3    <= '0;
      op_addr  <= '0;
      op_data  <= '0;
      op_err   <= 1'b0;
      load_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (accept) begin
        op_store <= bus.is_store;
        op_f3    <= bus.funct3;
        op_addr  <= bus.addr;
        op_data  <= bus.store_data[15:0];
        op_err   <= req_err;
        if (req_sw && !req_err) wdata_q <= bus.store_data;
      end
      if (state == CAP) begin
        if (op_store) wdata_q <= merged;
        else          load_q  <= formatted;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == RESP);
  assign bus.err         = (state == RESP) && op_err;
  assign bus.ram_read    = (state == RD);
  assign bus.ram_write   = (state == WR);
  assign bus.ram_address = op_addr[ADDR_WIDTH+1:2];
  assign bus.ram_data_in = wdata_q;
  assign bus.load_data   = load_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors, a mid-operation reset, then random traffic
// scored against a word-array reference model.
module tb_load_store_unit;
  localparam int AW = 16;

  typedef struct packed {
    logic [31:0] done_cyc;
    logic [1:0]  reads;
    logic [1:0]  writes;
    logic        err;
    logic [31:0] data;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] last_load = 32'h0;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_write) ram[bus.ram_address] <= bus.ram_data_in;
    if (bus.ram_read)  bus.ram_data_out <= ram[bus.ram_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [17:0] a,
                           input logic [31:0] d);
    bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.store_data = d;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (bus.busy && n < 20) begin @(negedge clk); n++; end
    ok = !bus.busy;
    if (!ok) timeout_fail("busy_wait");
  endtask

  // Reference model: computes the expected outcome from the request rules, then drives it.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [17:0] a,
                       input logic [31:0] d, input bit spurious);
    exp_t e;
    bit ok, bad;
    logic [31:0] w, mask, shifted;
    int sh, hs, lat;
    wait_idle(ok);
    if (!ok) return;
    bad = st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) bad = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
    w  = ref_mem[a[17:2]];
    sh = int'(a[1:0]) * 8;
    hs = a[1] ? 16 : 0;
    e.err = bad; e.reads = 0; e.writes = 0;
    if (bad) lat = 1;
    else if (!st) begin
      lat = 3; e.reads = 1;
      case (f3)
        3'd0: begin shifted = w >> sh; last_load = {{24{shifted[7]}}, shifted[7:0]}; end
        3'd4: begin shifted = w >> sh; last_load = {24'h0, shifted[7:0]}; end
        3'd1: begin shifted = w >> hs; last_load = {{16{shifted[15]}}, shifted[15:0]}; end
        3'd5: begin shifted = w >> hs; last_load = {16'h0, shifted[15:0]}; end
        default: last_load = w;
      endcase
    end else if (f3 == 3'd2) begin
      lat = 2; e.writes = 1; ref_mem[a[17:2]] = d;
    end else begin
      lat = 4; e.reads = 1; e.writes = 1;
      if (f3 == 3'd0) begin mask = 32'hFF << sh;   ref_mem[a[17:2]] = (w & ~mask) | ((d << sh) & mask); end
      else            begin mask = 32'hFFFF << hs; ref_mem[a[17:2]] = (w & ~mask) | ((d << hs) & mask); end
    end
    e.data = last_load;
    e.done_cyc = cyc + lat;
    exp_q.push_back(e);
    drive_req(st, f3, a, d);
    @(negedge clk);
    bus.start = 1'b0;
    if (spurious && bus.busy) begin
      drive_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 18'($urandom_range(0, 63)), $urandom);
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin rd_cnt = 0; wr_cnt = 0; end
      else begin
        check("strobe_exclusive", {31'h0, bus.ram_read & bus.ram_write}, 32'h0);
        if (bus.ram_read)  rd_cnt++;
        if (bus.ram_write) wr_cnt++;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done: done=1 with nothing outstanding, expected done=0 (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("err", {31'h0, bus.err}, {31'h0, e.err});
            check("load_data", bus.load_data, e.data);
            check("ram_reads", rd_cnt, {30'h0, e.reads});
            check("ram_writes", wr_cnt, {30'h0, e.writes});
          end
          rd_cnt = 0; wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    bit ok;
    int n;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'd0; bus.addr = '0; bus.store_data = '0;
    bus.ram_data_out = '0;
    for (int i = 0; i < (1 << AW); i++) begin ram[i] = 32'h0; ref_mem[i] = 32'h0; end
    ram[0] = 32'h8034_12F0; ref_mem[0] = 32'h8034_12F0;
    ram[1] = 32'h1111_1111; ref_mem[1] = 32'h1111_1111;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      {31'h0, bus.busy},      32'h0);
    check("rst_done",      {31'h0, bus.done},      32'h0);
    check("rst_err",       {31'h0, bus.err},       32'h0);
    check("rst_ram_read",  {31'h0, bus.ram_read},  32'h0);
    check("rst_ram_write", {31'h0, bus.ram_write}, 32'h0);
    check("rst_load_data", bus.load_data,          32'h0);
    check("rst_data_in",   bus.ram_data_in,        32'h0);
    check("rst_address",   {16'h0, bus.ram_address}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors on the preloaded words.
    do_op(0, 3'd0, 18'h3, 32'h0, 0);
    do_op(0, 3'd4, 18'h3, 32'h0, 0);
    do_op(0, 3'd1, 18'h2, 32'h0, 0);
    do_op(0, 3'd5, 18'h2, 32'h0, 0);
    do_op(0, 3'd2, 18'h0, 32'h0, 0);
    do_op(1, 3'd0, 18'h5, 32'h0000_00AB, 0);
    do_op(0, 3'd2, 18'h4, 32'h0, 0);
    do_op(1, 3'd2, 18'h8, 32'hDEAD_BEEF, 0);
    do_op(1, 3'd1, 18'hA, 32'h0000_CAFE, 0);
    do_op(0, 3'd2, 18'h8, 32'h0, 0);
    do_op(0, 3'd2, 18'h2, 32'h0, 0);
    do_op(1, 3'd1, 18'h1, 32'h0, 0);
    do_op(0, 3'd3, 18'h0, 32'h0, 0);
    do_op(1, 3'd4, 18'h0, 32'h0, 0);

    // Reset while a byte store sits in CAP.
    wait_idle(ok);
    drive_req(1, 3'd0, 18'h4, 32'h0000_0055);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("cap_state", {29'h0, bus.fsm_state}, 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy",  {31'h0, bus.busy},      32'h0);
    check("abort_write", {31'h0, bus.ram_write}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_load = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done",  {31'h0, bus.done},      32'h0);
      check("abort_no_write", {31'h0, bus.ram_write}, 32'h0);
    end
    @(negedge clk);
    do_op(0, 3'd2, 18'h4, 32'h0, 0);

    // Random traffic, occasionally poking start while busy.
    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 18'($urandom_range(0, 63)),
            $urandom, ($urandom_range(0, 3) == 0));
    end

    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 50) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) timeout_fail("drain");
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
